// File: rtl/fir_mac_nch.sv
// fir_mac_nch: multi-channel FIR MAC sharing one coefficient stream; per-channel
// full-precision accumulate, then round, arithmetic shift and saturate to DATA_W.
module fir_mac_nch #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS = 1021,
  parameter int ADDR_W = 10,
  parameter int NCH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sequencing,
  input  logic signed [COEF_W-1:0] coef,
  input  logic [NCH*DATA_W-1:0]    smp_in,
  output logic [ADDR_W-1:0]        coef_addr,
  output logic                     rd_en,
  output logic [NCH*DATA_W-1:0]    filtered,
  output logic                     valid,
  output logic                     busy
);
  localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (COEF_W - 2);
  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nx;
  logic seq_lo;
  logic mac;
  logic [ADDR_W-1:0] addr;
  logic signed [ACC_W-1:0] acc [NCH];
  logic signed [ACC_W-1:0] prod [NCH];
  logic signed [ACC_W-1:0] shf [NCH];
  logic [NCH*DATA_W-1:0] res;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (sequencing && seq_lo) ? RUN : IDLE;
      RUN:     state_nx = !sequencing ? IDLE : (addr == LAST) ? DRAIN : RUN;
      DRAIN:   state_nx = sequencing ? DONE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign rd_en = state == RUN;
  assign busy = state == RUN || state == DRAIN;
  assign coef_addr = addr;
  // data arrives one cycle behind its address, so the first RUN cycle has nothing to accumulate
  assign mac = (rd_en && addr != '0) || state == DRAIN;

  always_comb begin
    res = '0;
    for (int c = 0; c < NCH; c++) begin
      prod[c] = ACC_W'(coef) * ACC_W'(signed'(smp_in[c*DATA_W +: DATA_W]));
      shf[c] = (acc[c] + RND) >>> (COEF_W - 1);
      res[c*DATA_W +: DATA_W] = shf[c] > SAT_HI ? SAT_HI[DATA_W-1:0] :
                                shf[c] < SAT_LO ? SAT_LO[DATA_W-1:0] : shf[c][DATA_W-1:0];
    end
  end

  // seq_lo clears on reset so a level held high through reset is not taken as a rising edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      seq_lo <= 1'b0;
      addr <= '0;
      filtered <= '0;
      valid <= 1'b0;
      for (int c = 0; c < NCH; c++) acc[c] <= '0;
    end else begin
      state <= state_nx;
      seq_lo <= !sequencing;
      addr <= (state == RUN && state_nx == RUN) ? addr + 1'b1 : '0;
      valid <= state == DONE;
      if (state == DONE) filtered <= res;
      for (int c = 0; c < NCH; c++) begin
        if (state == IDLE) acc[c] <= '0;
        else if (mac) acc[c] <= acc[c] + prod[c];
      end
    end
  end
endmodule

// File: tb/tb_fir_mac_nch.sv
// tb_fir_mac_nch: randomized self-checking bench for fir_mac_nch at TAPS = 2, 4, 8 and 1021,
// with a ROM/queue model and an arithmetic reference for the filtered output.
module tb_fir_mac_nch;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] seq;
  logic [3:0][15:0] coef_r;
  logic [3:0][31:0] smp_r;
  logic [3:0][9:0] addr;
  logic [3:0] rd, valid, busy;
  logic [3:0][31:0] filt;
  logic signed [15:0] rom [4][1024];
  logic signed [15:0] sm [4][2][1024];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int TP = g == 0 ? 2 : g == 1 ? 4 : g == 2 ? 8 : 1021;
    fir_mac_nch #(.TAPS(TP)) dut (
      .clk(clk), .rst_n(rst_n), .sequencing(seq[g]), .coef(coef_r[g]), .smp_in(smp_r[g]),
      .coef_addr(addr[g]), .rd_en(rd[g]), .filtered(filt[g]), .valid(valid[g]), .busy(busy[g])
    );
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      coef_r[i] <= rom[i][addr[i]];
      if (rd[i]) smp_r[i] <= {sm[i][1][addr[i]], sm[i][0][addr[i]]};
    end
  end

  function automatic int tp_of(input int i);
    return i == 0 ? 2 : i == 1 ? 4 : i == 2 ? 8 : 1021;
  endfunction

  function automatic logic [31:0] model(input int i);
    logic [31:0] r;
    longint acc, s;
    r = '0;
    for (int c = 0; c < 2; c++) begin
      acc = 0;
      for (int k = 0; k < tp_of(i); k++) acc += longint'(rom[i][k]) * longint'(sm[i][c][k]);
      s = (acc + 16384) >>> 15;
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      r[c*16 +: 16] = s[15:0];
    end
    return r;
  endfunction

  task automatic fill(input int i, input int cv, input int s0, input int s1);
    for (int k = 0; k < 1024; k++) begin
      rom[i][k] = 16'(cv);
      sm[i][0][k] = 16'(s0);
      sm[i][1][k] = 16'(s1);
    end
  endtask

  task automatic fill_rand(input int i, input int cmax);
    for (int k = 0; k < 1024; k++) begin
      rom[i][k] = 16'(int'($urandom_range(0, 2 * cmax)) - cmax);
      sm[i][0][k] = 16'($urandom);
      sm[i][1][k] = 16'($urandom);
    end
  endtask

  task automatic do_run(input int i, output int lat, output logic [31:0] got, output logic after);
    seq[i] = 1'b0;
    @(negedge clk);
    seq[i] = 1'b1;
    lat = -1;
    for (int n = 1; n <= tp_of(i) + 20 && lat < 0; n++) begin
      @(negedge clk);
      if (valid[i]) lat = n;
    end
    got = filt[i];
    @(negedge clk);
    after = valid[i];
    seq[i] = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    seq = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({addr[i], rd[i], filt[i], valid[i], busy[i]} !== '0) begin
        bad++;
        $display("FAIL reset[%0d] got addr=%h rd=%b filt=%h valid=%b busy=%b want all 0",
                 i, addr[i], rd[i], filt[i], valid[i], busy[i]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int seen;
    fill(1, 16'h4000, 1000, -1000);
    seq[1] = 1'b0;
    @(negedge clk);
    seq[1] = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      total++;
      if (rd[1] !== (n <= 4) || busy[1] !== (n <= 5) || valid[1] !== (n == 7) ||
          addr[1] !== ((n <= 4) ? 10'(n - 1) : 10'd0)) begin
        bad++;
        $display("FAIL timing E0+%0d got rd=%b busy=%b valid=%b addr=%0d want rd=%b busy=%b valid=%b addr=%0d",
                 n, rd[1], busy[1], valid[1], addr[1], n <= 4, n <= 5, n == 7, (n <= 4) ? n - 1 : 0);
      end
      if (n >= 7) begin
        total++;
        if (filt[1] !== 32'hF830_07D0) begin
          bad++;
          $display("FAIL basic E0+%0d filtered got=%h want=f83007d0", n, filt[1]);
        end
      end
    end
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen += int'(busy[1]) + int'(valid[1]);
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL retrigger busy/valid cycles got=%0d want=0", seen);
    end
    seq[1] = 1'b0;
  endtask

  task automatic test_saturation;
    int lat;
    logic [31:0] got;
    logic after;
    fill(1, 16'h7FFF, 32767, -32768);
    do_run(1, lat, got, after);
    total++;
    if (lat != 7 || got !== 32'h8000_7FFF || after !== 1'b0) begin
      bad++;
      $display("FAIL saturation got lat=%0d filt=%h after=%b want lat=7 filt=80007fff after=0", lat, got, after);
    end
  endtask

  task automatic test_rounding;
    int lat;
    logic [31:0] got;
    logic after;
    fill(0, 1, 16384, 8191);
    do_run(0, lat, got, after);
    total++;
    if (lat != 5 || got !== 32'h0000_0001) begin
      bad++;
      $display("FAIL round_pos got lat=%0d filt=%h want lat=5 filt=00000001", lat, got);
    end
    fill(0, 1, -16384, -8191);
    do_run(0, lat, got, after);
    total++;
    if (lat != 5 || got !== 32'h0000_FFFF) begin
      bad++;
      $display("FAIL round_neg got lat=%0d filt=%h want lat=5 filt=0000ffff", lat, got);
    end
  endtask

  task automatic test_random;
    int lat;
    logic [31:0] got, exp;
    logic after;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 3; i++) begin
        fill_rand(i, (it % 2 == 1) ? 32767 : 600);
        exp = model(i);
        do_run(i, lat, got, after);
        total++;
        if (lat != tp_of(i) + 3 || got !== exp || after !== 1'b0) begin
          bad++;
          $display("FAIL random it=%0d taps=%0d got lat=%0d filt=%h after=%b want lat=%0d filt=%h after=0",
                   it, tp_of(i), lat, got, after, tp_of(i) + 3, exp);
        end
      end
    end
  endtask

  task automatic test_abort;
    int lat, vseen;
    logic [31:0] prior, got, exp;
    logic after;
    fill_rand(2, 600);
    exp = model(2);
    do_run(2, lat, prior, after);
    total++;
    if (prior !== exp) begin
      bad++;
      $display("FAIL abort_pre filt got=%h want=%h", prior, exp);
    end
    seq[2] = 1'b0;
    @(negedge clk);
    seq[2] = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (busy[2] !== 1'b1) begin
      bad++;
      $display("FAIL abort_busy_e3 got=%b want=1", busy[2]);
    end
    seq[2] = 1'b0;
    @(negedge clk);
    total++;
    if (busy[2] !== 1'b0 || rd[2] !== 1'b0 || addr[2] !== 10'd0) begin
      bad++;
      $display("FAIL abort_e4 got busy=%b rd=%b addr=%0d want 0 0 0", busy[2], rd[2], addr[2]);
    end
    vseen = 0;
    repeat (16) begin
      @(negedge clk);
      vseen += int'(valid[2]);
    end
    total++;
    if (vseen != 0 || filt[2] !== prior) begin
      bad++;
      $display("FAIL abort_hold got valids=%0d filt=%h want valids=0 filt=%h", vseen, filt[2], prior);
    end
    fill_rand(2, 32767);
    exp = model(2);
    do_run(2, lat, got, after);
    total++;
    if (lat != 11 || got !== exp) begin
      bad++;
      $display("FAIL abort_next got lat=%0d filt=%h want lat=11 filt=%h", lat, got, exp);
    end
  endtask

  task automatic test_reset_midrun;
    int lat, bseen;
    logic [31:0] got, exp;
    logic after;
    fill(2, 16'h4000, 1000, -1000);
    do_run(2, lat, got, after);
    total++;
    if (got !== 32'hF060_0FA0) begin
      bad++;
      $display("FAIL rst_pre filt got=%h want=f0600fa0", got);
    end
    seq[2] = 1'b0;
    @(negedge clk);
    seq[2] = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({addr[2], rd[2], filt[2], valid[2], busy[2]} !== '0) begin
      bad++;
      $display("FAIL rst_mid got addr=%h rd=%b filt=%h valid=%b busy=%b want all 0",
               addr[2], rd[2], filt[2], valid[2], busy[2]);
    end
    rst_n = 1'b1;
    bseen = 0;
    repeat (12) begin
      @(negedge clk);
      bseen += int'(busy[2]) + int'(valid[2]);
    end
    total++;
    if (bseen != 0) begin
      bad++;
      $display("FAIL rst_held_seq busy/valid cycles got=%0d want=0", bseen);
    end
    fill_rand(2, 600);
    exp = model(2);
    do_run(2, lat, got, after);
    total++;
    if (lat != 11 || got !== exp) begin
      bad++;
      $display("FAIL rst_next got lat=%0d filt=%h want lat=11 filt=%h", lat, got, exp);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [31:0] exp1, exp2, got;
    fill_rand(1, 600);
    exp1 = model(1);
    seq[1] = 1'b0;
    @(negedge clk);
    seq[1] = 1'b1;
    repeat (7) @(negedge clk);
    total++;
    if (valid[1] !== 1'b1 || filt[1] !== exp1) begin
      bad++;
      $display("FAIL b2b_first got valid=%b filt=%h want valid=1 filt=%h", valid[1], filt[1], exp1);
    end
    fill_rand(1, 32767);
    exp2 = model(1);
    seq[1] = 1'b0;
    @(negedge clk);
    seq[1] = 1'b1;
    lat = -1;
    got = '0;
    for (int m = 1; m <= 12; m++) begin
      @(negedge clk);
      if (valid[1] && lat < 0) begin
        lat = m;
        got = filt[1];
      end
    end
    total++;
    if (lat != 7 || got !== exp2) begin
      bad++;
      $display("FAIL b2b_second got lat=%0d filt=%h want lat=7 filt=%h", lat, got, exp2);
    end
    seq[1] = 1'b0;
  endtask

  task automatic test_hold_default;
    int nv, vat, nrd, addr_err;
    logic [31:0] got, exp;
    fill_rand(3, 600);
    exp = model(3);
    seq[3] = 1'b0;
    @(negedge clk);
    seq[3] = 1'b1;
    nv = 0;
    vat = -1;
    nrd = 0;
    addr_err = 0;
    got = '0;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      if (valid[3]) begin
        nv++;
        vat = n;
        got = filt[3];
      end
      if (rd[3]) begin
        if (int'(addr[3]) != nrd) addr_err++;
        nrd++;
      end else if (addr[3] != 10'd0) addr_err++;
    end
    seq[3] = 1'b0;
    total++;
    if (nv != 1 || vat != 1024) begin
      bad++;
      $display("FAIL hold_valid got count=%0d at=%0d want count=1 at=1024", nv, vat);
    end
    total++;
    if (nrd != 1021 || addr_err != 0) begin
      bad++;
      $display("FAIL hold_sweep got rd=%0d addr_errs=%0d want rd=1021 addr_errs=0", nrd, addr_err);
    end
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL hold_filt got=%h want=%h", got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    seq = '0;
    for (int i = 0; i < 4; i++) fill(i, 0, 0, 0);
    test_reset;
    test_basic;
    test_saturation;
    test_rounding;
    test_random;
    test_abort;
    test_reset_midrun;
    test_back_to_back;
    test_hold_default;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fir_mac_nch.md
# fir_mac_nch

Parametrised, multi-channel successor to the team's two-channel ROM-coefficient FIR. One coefficient stream is shared across NCH channels. Each channel's samples are multiply-accumulated over TAPS cycles, then rounded, saturated and presented with a one-cycle valid strobe. It sits between the sample queues and the equaliser summing stage and drives the coefficient ROM address and the queue read enable directly.

## Interface
- DATA_W, 16: signed sample and output width.
- COEF_W, 16: signed coefficient width; coefficients are Q1.(COEF_W-1).
- TAPS, 1021: taps per run; legal range 2 to 2^ADDR_W.
- ADDR_W, 10: coefficient address width.
- NCH, 2: channel count, 1 to 8; channel c occupies bits [c*DATA_W +: DATA_W].
- clk, in, 1: single clock, all logic on the rising edge.
- rst_n, in, 1: reset, synchronous and active-low.
- sequencing, in, 1: a rising edge starts a run; the level must stay high for the whole run.
- coef, in, COEF_W: ROM data; valid the cycle after coef_addr is issued.
- smp_in, in, NCH*DATA_W: queue data; valid the cycle after rd_en is issued.
- coef_addr, out, ADDR_W: ROM address.
- rd_en, out, 1: queue read strobe, one per tap.
- filtered, out, NCH*DATA_W: registered results, held between runs.
- valid, out, 1: one-cycle pulse when `filtered` updates.
- busy, out, 1: high in RUN and DRAIN.

## Operation
- Accumulator width ACC_W = DATA_W + COEF_W + ceil(log2(TAPS)). This is one signed accumulator per channel and cannot overflow.
- States:
  - IDLE: addr = 0, rd_en = 0, accumulators cleared.
  - RUN: issues addresses 0 to TAPS-1.
  - DRAIN: absorbs the final product.
  - DONE: performs the output update.
- Transitions:
  - IDLE to RUN when sequencing = 1 and the previous registered value of sequencing = 0, i.e. a rising edge.
  - RUN to DRAIN after address TAPS-1 is issued.
  - DRAIN to DONE.
  - DONE to IDLE.
- Abort: in RUN or DRAIN, sequencing = 0 sends the block to IDLE next cycle. No valid pulse; `filtered` holds its previous value; accumulators clear.
- Retrigger: holding sequencing high after DONE does not start a new run. It must go low and high again.
- MAC: each cycle after an issue, acc[c] += coef * smp_in[c]. These are signed full-precision products; exactly TAPS products per channel.
- Output per channel:
  - Rounded value r = acc + 2^(COEF_W-2).
  - Take s = r >>> (COEF_W-1), an arithmetic shift.
  - Saturate s to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Address wrap: coef_addr returns to 0 after TAPS-1. It never exceeds TAPS-1.

## Timing
- Reset values (rst_n low at an edge): state IDLE, coef_addr 0, rd_en 0, filtered all 0, valid 0, busy 0, accumulators 0, sequencing history 0. Reset overrides everything, including mid-run; a run in progress is discarded.
- Rising edge of sequencing sampled at edge E0: at E0+1 state is RUN, coef_addr = 0, rd_en = 1, busy = 1.
- coef_addr = k and rd_en = 1 during cycle E0+1+k, for k = 0..TAPS-1. The first MAC uses data present in cycle E0+2.
- DRAIN occupies cycle E0+TAPS+1, with rd_en = 0 and the last MAC.
- In DONE, cycle E0+TAPS+2, `filtered` is registered. Updated `filtered` and valid = 1 appear together in cycle E0+TAPS+3, as the block returns to IDLE.
- Latency from start to valid is TAPS+3 cycles. Minimum rising-edge spacing for back-to-back runs is TAPS+4 cycles.
- An abort sampled in the cycle DONE is entered still completes; the output commits.

## Test plan
- TAPS=4, NCH=2, coef = 0x4000 (0.5) for every tap, ch0 samples 1000, ch1 samples -1000 -> valid at E0+7, filtered ch0 = 2000, ch1 = -2000.
- Saturation: coef = 0x7FFF, ch0 samples 32767, ch1 samples -32768, TAPS=4 -> ch0 = 32767, ch1 = -32768. No wrap.
- Rounding: TAPS=2, coef = 0x0001, sample 16384 both taps -> acc = 32768, r = 49152, s = 1 -> filtered = 1. With sample 8191 -> acc = 16382, s = 0 -> filtered = 0.
- Abort: drop sequencing at E0+3 with TAPS=8 -> no valid, busy falls at E0+4, filtered keeps its prior value, next run produces a correct result.
- Reset mid-run (rst_n low at E0+5) -> all outputs 0 next cycle. Holding sequencing high through reset does not start a run until a fresh rising edge.
- Default parameters, sequencing held high for 3000 cycles -> exactly one valid pulse, at E0+1024. coef_addr sweeps 0..1020 once, and rd_en count = 1021.
